pwm_duty_ramp: RTL and testbench

Duty-cycle sequencer that sits directly upstream of the basic PWM stage and drives its 7-bit `duty_cycle` input (0–100 %). It produces a "breathing" profile: a linear ramp up to 100, a hold, a ramp down to 0, and a second hold, then either stops or repeats. Duty updates happen on a programmable step period so the PWM stage sees a stable value for whole PWM periods.

---
 rtl/pwm_duty_ramp.sv | 157 +++++++++++++++
 tb/tb_pwm_duty_ramp.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp.sv
// Breathing duty-cycle sequencer for the PWM stage: ramp up, hold, ramp down, hold.
// Optional square-law output curve when PWM_DUTY_RAMP_GAMMA_EN is defined.
module pwm_duty_ramp #(
  parameter int STEP_CYCLES = 1002,
  parameter int STEP_SIZE   = 1,
  parameter int HOLD_STEPS  = 50
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [6:0] duty_cycle,
  output logic       busy,
  output logic       done
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  typedef enum logic [2:0] {IDLE, UP, HOLD_HI, DOWN, HOLD_LO} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [HW-1:0]   hold_cnt;
  logic [6:0]      level;
  logic            tick;
  logic            hold_last;
  logic [6:0]      lvl_up;
  logic [6:0]      lvl_dn;

  // 8-bit sum never overflows since level <= 100 and STEP_SIZE <= 100
  function automatic logic [6:0] sat_up(input logic [6:0] lv);
    logic [7:0] sum;
    sum = {1'b0, lv} + 8'(STEP_SIZE);
    return (sum >= 8'd100) ? 7'd100 : sum[6:0];
  endfunction

  function automatic logic [6:0] sat_dn(input logic [6:0] lv);
    logic [7:0] dif;
    if ({1'b0, lv} <= 8'(STEP_SIZE)) begin
      return 7'd0;
    end
    dif = {1'b0, lv} - 8'(STEP_SIZE);
    return dif[6:0];
  endfunction

  assign tick      = (timer == TW'(STEP_CYCLES - 1));
  assign hold_last = (hold_cnt == HW'(HOLD_STEPS - 1));
  assign lvl_up    = sat_up(level);
  assign lvl_dn    = sat_dn(level);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      timer    <= '0;
      hold_cnt <= '0;
      level    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        timer    <= '0;
        hold_cnt <= '0;
        level    <= '0;
        busy     <= 1'b0;
      end else begin
        if (state != IDLE) begin
          timer <= tick ? '0 : timer + TW'(1);
        end
        case (state)
          IDLE: begin
            level <= '0;
            timer <= '0;
            if (start) begin
              state <= UP;
              busy  <= 1'b1;
            end
          end
          UP: begin
            if (tick) begin
              level <= lvl_up;
              if (lvl_up == 7'd100) begin
                state    <= HOLD_HI;
                hold_cnt <= '0;
              end
            end
          end
          HOLD_HI: begin
            if (tick) begin
              if (hold_last) begin
                state <= DOWN;
              end else begin
                hold_cnt <= hold_cnt + HW'(1);
              end
            end
          end
          DOWN: begin
            if (tick) begin
              level <= lvl_dn;
              if (lvl_dn == 7'd0) begin
                state    <= HOLD_LO;
                hold_cnt <= '0;
              end
            end
          end
          HOLD_LO: begin
            if (tick) begin
              if (hold_last) begin
                // loop_en matters only here, at the end of the low hold
                if (loop_en) begin
                  state <= UP;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end else begin
                hold_cnt <= hold_cnt + HW'(1);
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PWM_DUTY_RAMP_GAMMA_EN
  logic [6:0] duty_p1;

  function automatic logic [6:0] gamma_sq(input logic [6:0] lv);
    logic [13:0] sq;
    sq = 14'(lv) * 14'(lv);
    return 7'(sq / 14'd100);
  endfunction

  // Gamma stage: one extra register after level
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_p1 <= '0;
    end else begin
      duty_p1 <= gamma_sq(level);
    end
  end

  assign duty_cycle = duty_p1;
`else
  assign duty_cycle = level;
`endif

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed bench for pwm_duty_ramp: ramp, hold, loop, saturation, abort, async reset,
// and the gamma curve when PWM_DUTY_RAMP_GAMMA_EN is defined.
module tb_pwm_duty_ramp;

`ifdef PWM_DUTY_RAMP_GAMMA_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       loop_en = 1'b0;
  logic [6:0] duty_cycle, duty_sat;
  logic       busy, busy_sat;
  logic       done, done_sat;

  int n_chk = 0;
  int n_err = 0;
  int edge_n = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  pwm_duty_ramp #(.STEP_CYCLES(4), .STEP_SIZE(25), .HOLD_STEPS(2)) u_dut (
    .clk(clk), .rst_ni(rst_ni), .start(start), .stop(stop), .loop_en(loop_en),
    .duty_cycle(duty_cycle), .busy(busy), .done(done)
  );

  pwm_duty_ramp #(.STEP_CYCLES(4), .STEP_SIZE(30), .HOLD_STEPS(2)) u_sat (
    .clk(clk), .rst_ni(rst_ni), .start(start), .stop(stop), .loop_en(loop_en),
    .duty_cycle(duty_sat), .busy(busy_sat), .done(done_sat)
  );

  always @(negedge clk) if (done) done_cnt++;

  // Expected output for a given level; hand values: 25->6, 50->25, 75->56, 100->100
  function automatic int dexp(input int lvl);
`ifdef PWM_DUTY_RAMP_GAMMA_EN
    return (lvl * lvl) / 100;
`else
    return lvl;
`endif
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic go_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  // Pulse start for one edge; that edge becomes edge 0
  task automatic kick();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    edge_n = 0;
  endtask

  int ev[11] = '{3, 4, 8, 12, 16, 20, 24, 28, 32, 36, 40};
  int lv[11] = '{0, 25, 50, 75, 100, 100, 100, 75, 50, 25, 0};
  int sv[11] = '{0, 30, 60, 90, 100, 100, 100, 70, 40, 10, 0};
  int d0;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_duty", duty_cycle, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Basic ramp with a redundant start pulse mid-ramp; saturating twin alongside
    loop_en = 1'b0;
    d0 = done_cnt;
    kick();
    check("busy_rise", busy, 1);
    for (int i = 0; i < 11; i++) begin
      if (ev[i] == 8) begin
        go_to(5);
        start = 1'b1;
        go_to(6);
        start = 1'b0;
      end
      go_to(ev[i] + LAT);
      check($sformatf("ramp_e%0d", ev[i]), duty_cycle, dexp(lv[i]));
      check($sformatf("sat_e%0d", ev[i]), duty_sat, dexp(sv[i]));
    end
    go_to(47);
    check("pre_done", done, 0);
    check("pre_busy", busy, 1);
    go_to(48);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("sat_done", done_sat, 1);
    go_to(49);
    check("done_drop", done, 0);
    check("done_count", done_cnt - d0, 1);

    // Loop: no done, restart ramp, then stop
    loop_en = 1'b1;
    d0 = done_cnt;
    kick();
    go_to(48);
    check("loop_busy", busy, 1);
    go_to(52 + LAT);
    check("loop_e52", duty_cycle, dexp(25));
    check("loop_nodone", done_cnt - d0, 0);
    stop = 1'b1;
    go_to(53 + LAT);
    stop = 1'b0;
    check("loop_stop_busy", busy, 0);
    go_to(53 + 2 * LAT);
    check("loop_stop_duty", duty_cycle, 0);
    loop_en = 1'b0;

    // Abort at level 50
    d0 = done_cnt;
    kick();
    go_to(10);
    check("abort_pre", duty_cycle, dexp(50));
    stop = 1'b1;
    go_to(11);
    stop = 1'b0;
    check("abort_busy", busy, 0);
    go_to(11 + LAT);
    check("abort_duty", duty_cycle, 0);
    go_to(60);
    check("abort_nodone", done_cnt - d0, 0);
    check("abort_idle_duty", duty_cycle, 0);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    stop = 1'b0;
    edge_n = 0;
    check("startstop_busy", busy, 0);
    go_to(8);
    check("startstop_duty", duty_cycle, 0);

    // Asynchronous reset mid-cycle during DOWN
    kick();
    go_to(30);
    check("down_pre", duty_cycle, dexp(75));
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_duty", duty_cycle, 0);
    check("arst_busy", busy, 0);
    check("arst_sat", duty_sat, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(posedge clk); #1;
    d0 = done_cnt;
    kick();
    go_to(4 + LAT);
    check("replay_e4", duty_cycle, dexp(25));
    go_to(16 + LAT);
    check("replay_e16", duty_cycle, dexp(100));
    go_to(36 + LAT);
    check("replay_e36", duty_cycle, dexp(25));
    go_to(48);
    check("replay_done", done, 1);
    go_to(50);
    check("replay_done_cnt", done_cnt - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
